// File: rtl/compare_debounce.sv
// ---------------------------------------------------------------------------
// compare_debounce
//
// Purpose:
//   Debounces the greater/less/equal flags of a 4-bit comparator. A flag
//   class becomes the published verdict only after DEBOUNCE consecutive
//   identical valid samples. Every verdict change (including the first lock
//   after reset/clear) raises a one-cycle change pulse. A valid sample that
//   is not one-hot raises a one-cycle err pulse and restarts the run.
//
// Optional feature (compile-time macro CMP_EVENT_COUNT_EN):
//   When defined, parameter CNT_W and ports cnt_gt/cnt_lt/cnt_eq exist. They
//   count legal accepted samples per class and saturate at all-ones.
//   When undefined, the counters, their parameter and their ports are absent.
//
// Parameters:
//   DEBOUNCE  consecutive identical valid samples needed to lock (>= 1)
//   RUN_W     run-counter width, 2**RUN_W-1 >= DEBOUNCE
//   CNT_W     event-counter width (CMP_EVENT_COUNT_EN only)
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous reset, active-high
//   clear          synchronous soft clear, same effect as reset
//   valid_in       sample the three flags this cycle
//   greater/less/equal  comparator flags
//   stable_valid   a verdict is locked since reset/clear
//   stable_gt/lt/eq     one-hot locked verdict (all 0 when none)
//   change         one-cycle pulse on every verdict change
//   err            one-cycle pulse on a non-one-hot valid sample
//   cnt_gt/lt/eq   per-class accepted-sample counters (optional)
// ---------------------------------------------------------------------------
module compare_debounce #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned RUN_W    = 4
`ifdef CMP_EVENT_COUNT_EN
  ,
  parameter int unsigned CNT_W    = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid_in,
  input  logic             greater,
  input  logic             less,
  input  logic             equal,
  output logic             stable_valid,
  output logic             stable_gt,
  output logic             stable_lt,
  output logic             stable_eq,
  output logic             change,
  output logic             err
`ifdef CMP_EVENT_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [CNT_W-1:0] cnt_eq
`endif
);

  // Flag class of a sample; CLS_NONE doubles as "no candidate/no verdict".
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_GT   = 2'd1,
    CLS_LT   = 2'd2,
    CLS_EQ   = 2'd3
  } cls_t;

  typedef enum logic [0:0] {
    S_NOVERDICT = 1'b0,
    S_VERDICT   = 1'b1
  } state_t;

  localparam logic [RUN_W-1:0] RUN_MAX  = {RUN_W{1'b1}};
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(DEBOUNCE);

  // True when exactly one of the three flags is set.
  function automatic logic f_is_onehot3(input logic [2:0] flags);
    logic ok;
    case (flags)
      3'b100, 3'b010, 3'b001: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Map a flag vector {greater, less, equal} to its class.
  function automatic cls_t f_classify(input logic [2:0] flags);
    cls_t c;
    case (flags)
      3'b100:  c = CLS_GT;
      3'b010:  c = CLS_LT;
      3'b001:  c = CLS_EQ;
      default: c = CLS_NONE;
    endcase
    return c;
  endfunction

  // Decode a class into the one-hot {gt, lt, eq} verdict bits.
  function automatic logic [2:0] f_decode(input cls_t c);
    logic [2:0] bits;
    case (c)
      CLS_GT:  bits = 3'b100;
      CLS_LT:  bits = 3'b010;
      CLS_EQ:  bits = 3'b001;
      default: bits = 3'b000;
    endcase
    return bits;
  endfunction

  // Registers
  state_t           r_state;
  cls_t             r_cand;
  logic [RUN_W-1:0] r_run;
  cls_t             r_verdict;
  logic             r_stable_valid;
  logic [2:0]       r_stable_bits;
  logic             r_change;
  logic             r_err;

  // Combinational next values
  logic [2:0]       w_flags;
  logic             w_sample_ok;
  logic             w_sample_bad;
  cls_t             w_cls;
  logic [RUN_W-1:0] w_run_inc;
  cls_t             w_cand_next;
  logic [RUN_W-1:0] w_run_next;
  logic             w_lock;
  state_t           w_state_next;
  cls_t             w_verdict_next;
  logic             w_change_next;
  logic             w_err_next;

  assign w_flags      = {greater, less, equal};
  assign w_sample_ok  = valid_in & f_is_onehot3(w_flags);
  assign w_sample_bad = valid_in & ~f_is_onehot3(w_flags);
  assign w_cls        = f_classify(w_flags);
  assign w_run_inc    = (r_run == RUN_MAX) ? r_run : (r_run + RUN_W'(1));

  // Candidate/run update; clear wins over any sample in the same cycle.
  always_comb begin
    w_cand_next = r_cand;
    w_run_next  = r_run;
    if (clear) begin
      w_cand_next = CLS_NONE;
      w_run_next  = '0;
    end else if (w_sample_ok) begin
      if (w_cls == r_cand) begin
        w_run_next = w_run_inc;
      end else begin
        w_cand_next = w_cls;
        w_run_next  = RUN_W'(1);
      end
    end else if (w_sample_bad) begin
      w_cand_next = CLS_NONE;
      w_run_next  = '0;
    end else begin
      // No sample: candidate and run are held so gaps do not break a run.
      w_cand_next = r_cand;
      w_run_next  = r_run;
    end
  end

  // A lock happens on the very edge the run reaches DEBOUNCE with a new class.
  assign w_lock = ~clear & w_sample_ok & (w_run_next == RUN_LOCK) &
                  (w_cand_next != r_verdict);

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = S_NOVERDICT;
    end else begin
      case (r_state)
        S_NOVERDICT: begin
          if (w_lock) begin
            w_state_next = S_VERDICT;
          end else begin
            w_state_next = S_NOVERDICT;
          end
        end
        S_VERDICT: w_state_next = S_VERDICT;
        default:   w_state_next = S_NOVERDICT;
      endcase
    end
  end

  // FSM output logic: next values for the registered verdict and pulses.
  always_comb begin
    w_verdict_next = r_verdict;
    w_change_next  = 1'b0;
    w_err_next     = 1'b0;
    if (clear) begin
      w_verdict_next = CLS_NONE;
    end else begin
      if (w_lock) begin
        w_verdict_next = w_cand_next;
        w_change_next  = 1'b1;
      end else begin
        w_verdict_next = r_verdict;
      end
      w_err_next = w_sample_bad;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_NOVERDICT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Candidate, run and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand         <= CLS_NONE;
      r_run          <= '0;
      r_verdict      <= CLS_NONE;
      r_stable_valid <= 1'b0;
      r_stable_bits  <= 3'b000;
      r_change       <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_cand         <= w_cand_next;
      r_run          <= w_run_next;
      r_verdict      <= w_verdict_next;
      r_stable_valid <= (w_state_next == S_VERDICT);
      r_stable_bits  <= f_decode(w_verdict_next);
      r_change       <= w_change_next;
      r_err          <= w_err_next;
    end
  end

  assign stable_valid = r_stable_valid;
  assign stable_gt    = r_stable_bits[2];
  assign stable_lt    = r_stable_bits[1];
  assign stable_eq    = r_stable_bits[0];
  assign change       = r_change;
  assign err          = r_err;

`ifdef CMP_EVENT_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt_gt;
  logic [CNT_W-1:0] r_cnt_lt;
  logic [CNT_W-1:0] r_cnt_eq;
  logic [CNT_W-1:0] w_cnt_gt_next;
  logic [CNT_W-1:0] w_cnt_lt_next;
  logic [CNT_W-1:0] w_cnt_eq_next;

  // Per-class saturating counters of legal samples; cleared samples are dropped.
  always_comb begin
    w_cnt_gt_next = r_cnt_gt;
    w_cnt_lt_next = r_cnt_lt;
    w_cnt_eq_next = r_cnt_eq;
    if (clear) begin
      w_cnt_gt_next = '0;
      w_cnt_lt_next = '0;
      w_cnt_eq_next = '0;
    end else if (w_sample_ok) begin
      case (w_cls)
        CLS_GT: begin
          if (r_cnt_gt != CNT_MAX) begin
            w_cnt_gt_next = r_cnt_gt + CNT_W'(1);
          end else begin
            w_cnt_gt_next = r_cnt_gt;
          end
        end
        CLS_LT: begin
          if (r_cnt_lt != CNT_MAX) begin
            w_cnt_lt_next = r_cnt_lt + CNT_W'(1);
          end else begin
            w_cnt_lt_next = r_cnt_lt;
          end
        end
        CLS_EQ: begin
          if (r_cnt_eq != CNT_MAX) begin
            w_cnt_eq_next = r_cnt_eq + CNT_W'(1);
          end else begin
            w_cnt_eq_next = r_cnt_eq;
          end
        end
        default: begin
          w_cnt_gt_next = r_cnt_gt;
          w_cnt_lt_next = r_cnt_lt;
          w_cnt_eq_next = r_cnt_eq;
        end
      endcase
    end else begin
      w_cnt_gt_next = r_cnt_gt;
      w_cnt_lt_next = r_cnt_lt;
      w_cnt_eq_next = r_cnt_eq;
    end
  end

  // Event counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_gt <= '0;
      r_cnt_lt <= '0;
      r_cnt_eq <= '0;
    end else begin
      r_cnt_gt <= w_cnt_gt_next;
      r_cnt_lt <= w_cnt_lt_next;
      r_cnt_eq <= w_cnt_eq_next;
    end
  end

  assign cnt_gt = r_cnt_gt;
  assign cnt_lt = r_cnt_lt;
  assign cnt_eq = r_cnt_eq;
`endif

endmodule

// File: tb/tb_compare_debounce.sv
// Bench for compare_debounce with DEBOUNCE=3 (and CNT_W=2 when the
// CMP_EVENT_COUNT_EN counters are built in).
module tb_compare_debounce;

  localparam int DEB = 3;
  localparam logic [2:0] F_GT  = 3'b100;
  localparam logic [2:0] F_LT  = 3'b010;
  localparam logic [2:0] F_EQ  = 3'b001;
  localparam logic [2:0] F_BAD = 3'b110;

  logic clk = 1'b0;
  logic rst, clear, valid_in, greater, less, equal;
  logic stable_valid, stable_gt, stable_lt, stable_eq, change, err;
`ifdef CMP_EVENT_COUNT_EN
  localparam int CW = 2;
  logic [CW-1:0] cnt_gt, cnt_lt, cnt_eq;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  // Reference model: history of legal sample classes (1=gt 2=lt 3=eq)
  int m_hist[$];
  int m_verdict;
  int m_valid;
  int m_change;
  int m_err;
  int m_cnt[4];

  always #5 clk = ~clk;

  compare_debounce #(
    .DEBOUNCE(DEB),
    .RUN_W   (4)
`ifdef CMP_EVENT_COUNT_EN
    ,
    .CNT_W   (CW)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .valid_in    (valid_in),
    .greater     (greater),
    .less        (less),
    .equal       (equal),
    .stable_valid(stable_valid),
    .stable_gt   (stable_gt),
    .stable_lt   (stable_lt),
    .stable_eq   (stable_eq),
    .change      (change),
    .err         (err)
`ifdef CMP_EVENT_COUNT_EN
    ,
    .cnt_gt      (cnt_gt),
    .cnt_lt      (cnt_lt),
    .cnt_eq      (cnt_eq)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_verdict = 0;
    m_valid   = 0;
    m_change  = 0;
    m_err     = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Expected outputs after one clock edge with the given inputs.
  task automatic model_edge(input logic c, input logic v, input logic [2:0] f);
    int ones;
    int cls;
    int trail;
    m_change = 0;
    m_err    = 0;
    if (c) begin
      model_reset();
    end else if (v) begin
      ones = int'(f[2]) + int'(f[1]) + int'(f[0]);
      if (ones != 1) begin
        m_err = 1;
        m_hist.delete();
      end else begin
        cls = f[2] ? 1 : (f[1] ? 2 : 3);
        m_hist.push_back(cls);
        trail = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
          if (m_hist[i] == cls) trail++;
          else break;
        end
        if (trail == DEB && cls != m_verdict) begin
          m_verdict = cls;
          m_valid   = 1;
          m_change  = 1;
        end
        if (m_cnt[cls] < 3) m_cnt[cls]++;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model on that edge.
  task automatic step(input logic c, input logic v, input logic [2:0] f);
    clear    = c;
    valid_in = v;
    {greater, less, equal} = f;
    @(posedge clk);
    model_edge(c, v, f);
    #1;
    clear    = 1'b0;
    valid_in = 1'b0;
    {greater, less, equal} = 3'b000;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_stable_valid", 32'(stable_valid), 32'(m_valid));
      chk("m_stable_gt",    32'(stable_gt),    32'(m_verdict == 1));
      chk("m_stable_lt",    32'(stable_lt),    32'(m_verdict == 2));
      chk("m_stable_eq",    32'(stable_eq),    32'(m_verdict == 3));
      chk("m_change",       32'(change),       32'(m_change));
      chk("m_err",          32'(err),          32'(m_err));
`ifdef CMP_EVENT_COUNT_EN
      chk("m_cnt_gt", 32'(cnt_gt), 32'(m_cnt[1]));
      chk("m_cnt_lt", 32'(cnt_lt), 32'(m_cnt[2]));
      chk("m_cnt_eq", 32'(cnt_eq), 32'(m_cnt[3]));
`endif
    end
  end

  logic [3:0] mix [16];

  initial begin
    rst = 1'b1; clear = 1'b0; valid_in = 1'b0;
    {greater, less, equal} = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid",  32'(stable_valid), 32'd0);
    chk("reset_stable", 32'({stable_gt, stable_lt, stable_eq}), 32'd0);
    chk("reset_pulses", 32'({change, err}), 32'd0);
    rst = 1'b0;
    check_en = 1'b1;

    // Reset in the middle of a run of 2 clears everything at once.
    step(1'b0, 1'b1, F_GT);
    step(1'b0, 1'b1, F_GT);
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_valid", 32'(stable_valid), 32'd0);
    chk("midrst_all",   32'({stable_gt, stable_lt, stable_eq, change, err}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic lock, and the interrupted run did not survive the reset.
    step(1'b0, 1'b1, F_GT);
    step(1'b0, 1'b1, F_GT);
    chk("basic_nolock2", 32'(stable_valid), 32'd0);
    step(1'b0, 1'b1, F_GT);
    chk("basic_gt",     32'(stable_gt),    32'd1);
    chk("basic_valid",  32'(stable_valid), 32'd1);
    chk("basic_change", 32'(change),       32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, F_GT);
      chk("basic_nopulse", 32'(change), 32'd0);
    end

    // Clear with an illegal sample in the same cycle: sample dropped.
    step(1'b1, 1'b1, F_BAD);
    chk("clear_valid", 32'(stable_valid), 32'd0);
    chk("clear_err",   32'(err),          32'd0);

    // Broken run, then the 3rd consecutive GT locks.
    step(1'b0, 1'b1, F_GT);
    step(1'b0, 1'b1, F_GT);
    step(1'b0, 1'b1, F_LT);
    step(1'b0, 1'b1, F_GT);
    step(1'b0, 1'b1, F_GT);
    chk("broken_none", 32'(stable_valid), 32'd0);
    step(1'b0, 1'b1, F_GT);
    chk("broken_lock", 32'({stable_gt, change}), 32'b11);

    // Verdict switch GT -> EQ.
    step(1'b0, 1'b1, F_EQ);
    step(1'b0, 1'b1, F_EQ);
    chk("switch_hold", 32'({stable_gt, stable_eq}), 32'b10);
    step(1'b0, 1'b1, F_EQ);
    chk("switch_eq", 32'({stable_gt, stable_eq, change}), 32'b011);
    step(1'b0, 1'b0, 3'b000);
    chk("switch_once", 32'(change), 32'd0);

    // Gap tolerance: flags ignored while valid_in is low.
    step(1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b1, F_GT);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'b111);
    step(1'b0, 1'b1, F_GT);
    chk("gap_nolock", 32'(stable_valid), 32'd0);
    step(1'b0, 1'b1, F_GT);
    chk("gap_lock", 32'({stable_valid, stable_gt, change, err}), 32'b1110);

    // Illegal flags hold the LT verdict and restart the run.
    step(1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, F_LT);
    chk("ill_lt", 32'(stable_lt), 32'd1);
    step(1'b0, 1'b1, F_BAD);
    chk("ill_err", 32'({err, stable_lt, stable_valid}), 32'b111);
    step(1'b0, 1'b1, F_LT);
    chk("ill_errpulse", 32'(err), 32'd0);
    step(1'b0, 1'b1, F_LT);
    step(1'b0, 1'b1, F_LT);
    chk("ill_nochange", 32'(change), 32'd0);
    step(1'b0, 1'b1, 3'b000);
    chk("ill_zero_err", 32'(err), 32'd1);
    step(1'b0, 1'b1, 3'b111);
    chk("ill_three_err", 32'(err), 32'd1);

`ifdef CMP_EVENT_COUNT_EN
    // Counter saturation at 3 and clearing.
    step(1'b1, 1'b0, 3'b000);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, F_GT);
    chk("cnt_sat", 32'(cnt_gt), 32'd3);
    chk("cnt_lt0", 32'(cnt_lt), 32'd0);
    step(1'b1, 1'b0, 3'b000);
    chk("cnt_clear", 32'({cnt_gt, cnt_lt, cnt_eq}), 32'd0);
    chk("cnt_clear_valid", 32'(stable_valid), 32'd0);
`endif

    // Mixed directed sequence {valid, gt, lt, eq}, checked by the model.
    mix = '{4'b1001, 4'b1001, 4'b0100, 4'b1001, 4'b1010, 4'b1010, 4'b1010,
            4'b1011, 4'b1010, 4'b1010, 4'b1010, 4'b1100, 4'b1100, 4'b0000,
            4'b1100, 4'b1001};
    for (int i = 0; i < 16; i++) step(1'b0, mix[i][3], mix[i][2:0]);
    step(1'b0, 1'b0, 3'b000);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
